// File: rtl/fetch_pkg.sv
// Shared types, constants and the PC legality rule for the instruction-fetch block.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_t;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   // One prefetch slot: the PC travels with its instruction word.
   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // A PC may be fetched only if word aligned and the whole word lies inside memory.
   function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] mem_bytes);
      return (pc[1:0] == 2'b00) && (pc <= mem_bytes - 32'd4);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head data comes straight from registered storage.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: push ignored when full unless a pop happens the same edge; flush beats push/pop.
//
// Ports: clk, rst_n (async, active low); push/push_dat write side; pop read side;
//        flush empties the FIFO; head_dat, count, full, empty status.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_dat,
   input  logic                         pop,
   input  logic                         flush,
   output logic [WIDTH-1:0]             head_dat,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop & ~empty;
   // A full FIFO can still accept a write when its head leaves on the same edge.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush) begin
         cnt_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr] <= push_dat;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
      end
   end

   assign head_dat = mem_q[rd_ptr];
   assign count    = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational memory, queues {pc, instr}.
// Latency: first instruction valid after the 2nd edge out of reset; 1-cycle bubble after a redirect.
// Backpressure: PC holds while the prefetch FIFO is full and decode is not accepting.
//
// Ports: clk, rst_n (async, active low); imem_addr/imem_rdata memory side;
//        redirect_valid/redirect_pc PC change request; out_valid/out_ready/out_instr/out_pc
//        decode handshake; fault is high while fetch is halted on an illegal PC.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 1024,
   parameter int          DEPTH     = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [31:0]        imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [31:0]        out_pc,
   output logic               fault
);

   localparam int CW = $clog2(DEPTH+1);

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          push, pop, flush;
   logic          pc_ok, redir_ok;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  push_ent, head_ent;

   assign pc_ok    = pc_legal(pc_q, 32'(MEM_BYTES));
   assign redir_ok = pc_legal(redirect_pc, 32'(MEM_BYTES));
   assign pop      = out_valid & out_ready;
   assign push_ent = '{pc: pc_q, instr: imem_rdata};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         // One settling cycle out of reset; redirects here are dropped.
         ST_IDLE: state_d = ST_RUN;
         ST_RUN: begin
            if (redirect_valid) begin
               flush   = 1'b1;
               pc_d    = redirect_pc;
               state_d = redir_ok ? ST_RUN : ST_FAULT;
            end else if (!pc_ok) begin
               state_d = ST_FAULT;
            end else if (!fifo_full || pop) begin
               push = 1'b1;
               pc_d = pc_q + PC_STEP;
            end
         end
         // Queued entries keep draining; only a legal redirect restarts fetching.
         ST_FAULT: begin
            if (redirect_valid) begin
               flush   = 1'b1;
               pc_d    = redirect_pc;
               state_d = redir_ok ? ST_RUN : ST_FAULT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .flush    (flush),
      .head_dat (head_ent),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // The status flags must always agree with the occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n) begin
         assert (fifo_empty == (fifo_count == '0));
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = ~fifo_empty;
   assign out_instr = head_ent.instr;
   assign out_pc    = head_ent.pc;
   assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed stimulus, queue-based reference model, per-cycle compare.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid, fault;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr, out_pc;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   fetch_ctrl #(
      .RESET_PC  (32'h0),
      .MEM_BYTES (1024),
      .DEPTH     (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fault          (fault)
   );

   // Program image as words; memory itself is a little-endian byte array.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h1111_1111;
         32'h4:   return 32'h2222_2222;
         32'h8:   return 32'h3333_3333;
         default: return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   logic [7:0] mem [1024];
   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [31:0] w;
         w = word_at(32'(i * 4));
         mem[i*4]   = w[7:0];
         mem[i*4+1] = w[15:8];
         mem[i*4+2] = w[23:16];
         mem[i*4+3] = w[31:24];
      end
   end

   assign imem_rdata = {mem[10'(imem_addr + 32'd3)], mem[10'(imem_addr + 32'd2)],
                        mem[10'(imem_addr + 32'd1)], mem[10'(imem_addr)]};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a PC, a halted flag and a queue of at most two fetched words.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc = 32'h0;
   bit          m_fault = 1'b0;
   bit          m_started = 1'b0;

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a <= 32'd1020);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_pc      = 32'h0;
         m_fault   = 1'b0;
         m_started = 1'b0;
      end else if (!m_started) begin
         m_started = 1'b1;
      end else if (redirect_valid) begin
         mq.delete();
         m_pc    = redirect_pc;
         m_fault = !legal(redirect_pc);
      end else begin
         if (mq.size() != 0 && out_ready) void'(mq.pop_front());
         if (!m_fault) begin
            if (!legal(m_pc)) m_fault = 1'b1;
            else if (mq.size() < 2) begin
               mq.push_back({m_pc, word_at(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_valid", 32'(out_valid), 32'(mq.size() != 0));
         check("cmp_addr", imem_addr, m_pc);
         check("cmp_fault", 32'(fault), 32'(m_fault));
         if (mq.size() != 0) begin
            check("cmp_pc", out_pc, mq[0].pc);
            check("cmp_instr", out_instr, mq[0].instr);
         end
      end
   end

   // Inputs change on the falling edge; one call covers exactly one rising edge.
   task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      @(negedge clk);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_fault", 32'(fault), 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_instr", out_instr, 32'h0);
      rst_n = 1'b1;

      // Stream from reset
      step(1'b0, 32'h0, 1'b1);
      check("idle_valid", 32'(out_valid), 32'h0);
      step(1'b0, 32'h0, 1'b1);
      check("first_valid", 32'(out_valid), 32'h1);
      check("first_pc", out_pc, 32'h0);
      check("first_instr", out_instr, 32'h1111_1111);
      step(1'b0, 32'h0, 1'b1);
      check("second_pc", out_pc, 32'h4);
      check("second_instr", out_instr, 32'h2222_2222);
      step(1'b0, 32'h0, 1'b1);
      check("third_pc", out_pc, 32'h8);
      check("third_instr", out_instr, 32'h3333_3333);

      // Backpressure: PC stalls once two entries are queued
      repeat (5) step(1'b0, 32'h0, 1'b0);
      check("bp_addr", imem_addr, 32'h10);
      check("bp_head", out_pc, 32'h8);
      step(1'b0, 32'h0, 1'b1);
      check("fullpop_head", out_pc, 32'hC);
      check("fullpop_addr", imem_addr, 32'h14);

      // Full + pop + redirect: flush wins
      step(1'b1, 32'h40, 1'b1);
      check("redir_valid", 32'(out_valid), 32'h0);
      check("redir_addr", imem_addr, 32'h40);
      step(1'b0, 32'h0, 1'b1);
      check("redir_pc", out_pc, 32'h40);
      check("redir_instr", out_instr, 32'hC0DE_0040);
      step(1'b0, 32'h0, 1'b1);
      check("redir_next", out_pc, 32'h44);

      // Misaligned redirect halts fetch
      step(1'b1, 32'h42, 1'b1);
      check("mis_fault", 32'(fault), 32'h1);
      repeat (2) step(1'b0, 32'h0, 1'b1);
      check("mis_nopush", 32'(out_valid), 32'h0);
      check("mis_addr", imem_addr, 32'h42);

      // Legal redirect recovers
      step(1'b1, 32'h10, 1'b1);
      check("rec_fault", 32'(fault), 32'h0);
      step(1'b0, 32'h0, 1'b1);
      check("rec_pc", out_pc, 32'h10);
      check("rec_instr", out_instr, 32'hC0DE_0010);

      // Run off the end of memory, with entries draining after the fault
      step(1'b1, 32'h3F0, 1'b0);
      repeat (2) step(1'b0, 32'h0, 1'b0);
      check("end_head", out_pc, 32'h3F0);
      check("end_addr", imem_addr, 32'h3F8);
      repeat (2) step(1'b0, 32'h0, 1'b1);
      check("end_pre_fault", 32'(fault), 32'h0);
      check("end_addr400", imem_addr, 32'h400);
      step(1'b0, 32'h0, 1'b1);
      check("end_fault", 32'(fault), 32'h1);
      check("end_drain_pc", out_pc, 32'h3FC);
      check("end_drain_instr", out_instr, 32'hC0DE_03FC);
      step(1'b0, 32'h0, 1'b1);
      check("end_empty", 32'(out_valid), 32'h0);

      // Restart, then reset in the middle of a cycle
      step(1'b1, 32'h0, 1'b1);
      repeat (2) step(1'b0, 32'h0, 1'b1);
      check("pre_arst_pc", out_pc, 32'h4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'h0);
      check("arst_addr", imem_addr, 32'h0);
      check("arst_pc", out_pc, 32'h0);
      check("arst_instr", out_instr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Redirect while idle is dropped
      step(1'b1, 32'h80, 1'b1);
      check("idle_redir_addr", imem_addr, 32'h0);
      step(1'b0, 32'h0, 1'b1);
      check("post_arst_pc", out_pc, 32'h0);
      check("post_arst_instr", out_instr, 32'h1111_1111);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
